// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared constants, enums and helpers for reaction_stats
// Build option: STATS_WORST_EN adds the worst-time display mode (modes 0..3);
// without it the display mode cycles LAST -> BEST -> AVG -> LAST.
package reaction_pkg;

    localparam int TIME_W = 14;

    typedef enum logic [1:0] {
        MODE_LAST  = 2'd0,
        MODE_BEST  = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_WORST = 2'd3
    } disp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DIVIDE = 2'd2
    } stat_state_e;

    function automatic disp_mode_e next_mode(input disp_mode_e m);
`ifdef STATS_WORST_EN
        return disp_mode_e'(m + 2'd1);
`else
        return (m == MODE_AVG) ? MODE_LAST : disp_mode_e'(m + 2'd1);
`endif
    endfunction

endpackage

// File: rtl/stats_div.sv
// rtl/stats_div.sv - sequential restoring divider for the trial average
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            abort any divide in progress
//   start            load dividend/divisor and begin (SUM_W iterations)
//   dividend[SUM_W]  window sum
//   divisor[CNT_W]   window entry count (never zero when started)
//   quotient[WIDTH]  floor(dividend/divisor), valid when done pulses
//   done             one-cycle pulse after the last iteration
module stats_div #(
    parameter int WIDTH = 14,
    parameter int SUM_W = 17,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int IT_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W+1:0] trial_rem;
    logic [CNT_W+1:0] trial_diff;

    always_comb begin
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        // Shift the next dividend bit into the partial remainder; the top
        // bit of the difference is the borrow that decides restore/keep.
        trial_rem  = {rem_q, quo_q[SUM_W-1]};
        trial_diff = trial_rem - {2'b00, dsr_q};
        if (clear) begin
            busy_d = 1'b0;
            iter_d = '0;
        end else if (start) begin
            quo_d  = dividend;
            dsr_d  = divisor;
            rem_d  = '0;
            iter_d = IT_W'(SUM_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial_diff[CNT_W+1]) begin
                rem_d = trial_diff[CNT_W:0];
                quo_d = {quo_q[SUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial_rem[CNT_W:0];
                quo_d = {quo_q[SUM_W-2:0], 1'b0};
            end
            iter_d = iter_q - IT_W'(1);
            if (iter_q == IT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Quotient never exceeds the largest stored time, so the low bits suffice.
    assign quotient = quo_q[WIDTH-1:0];
    assign done     = done_q;

endmodule

// File: rtl/reaction_stats.sv
// rtl/reaction_stats.sv - sliding-window reaction-time statistics and display select
// Build option: STATS_WORST_EN adds the worst register and display mode 3.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   trial_valid, rect_time   completed trial and its time (accepted when ready)
//   overflow                 trial timed out: counted in miss_cnt, not stored
//   mode_btn                 advance display mode (any state)
//   clear                    discard all statistics, keep display mode
//   ready                    trial_valid will be accepted this cycle
//   disp_time, disp_mode     selected value and which value it is
//   trial_cnt, miss_cnt      window occupancy, overflow count (both saturate)
//   stats_valid              average reflects the current window
module reaction_stats
    import reaction_pkg::*;
#(
    parameter int WIDTH = TIME_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trial_valid,
    input  logic [WIDTH-1:0] rect_time,
    input  logic             overflow,
    input  logic             mode_btn,
    input  logic             clear,
    output logic             ready,
    output logic [WIDTH-1:0] disp_time,
    output logic [1:0]       disp_mode,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [3:0]       miss_cnt,
    output logic             stats_valid
);

    localparam int SUM_W = WIDTH + $clog2(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    stat_state_e      state_q, state_d;
    disp_mode_e       mode_q, mode_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] best_q, best_d;
`ifdef STATS_WORST_EN
    logic [WIDTH-1:0] worst_q, worst_d;
`endif
    logic [WIDTH-1:0] avg_q, avg_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       miss_q, miss_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] ring_q [DEPTH];
    logic [WIDTH-1:0] ring_d [DEPTH];
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] disp_q, disp_d;

    logic [WIDTH-1:0] evicted;
    logic             div_start;
    logic [WIDTH-1:0] div_quot;
    logic             div_done;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        last_d    = last_q;
        best_d    = best_q;
`ifdef STATS_WORST_EN
        worst_d   = worst_q;
`endif
        avg_d     = avg_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        ptr_d     = ptr_q;
        ring_d    = ring_q;
        valid_d   = valid_q;
        disp_d    = disp_q;
        div_start = 1'b0;
        // Once the window is full, the slot about to be overwritten is the oldest.
        evicted   = ring_q[ptr_q];

        if (mode_btn) begin
            mode_d = next_mode(mode_q);
        end

        if (clear) begin
            state_d = ST_IDLE;
            last_d  = '0;
            best_d  = '1;
`ifdef STATS_WORST_EN
            worst_d = '0;
`endif
            avg_d   = '0;
            sum_d   = '0;
            cnt_d   = '0;
            miss_d  = '0;
            ptr_d   = '0;
            valid_d = 1'b0;
            disp_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_d[i] = '0;
            end
        end else begin
            if (cnt_q == '0) begin
                disp_d = '0;
            end else begin
                case (mode_q)
                    MODE_LAST:  disp_d = last_q;
                    MODE_BEST:  disp_d = best_q;
                    MODE_AVG:   disp_d = avg_q;
`ifdef STATS_WORST_EN
                    MODE_WORST: disp_d = worst_q;
`endif
                    default:    disp_d = '0;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (trial_valid) begin
                        if (overflow) begin
                            if (miss_q != 4'hF) begin
                                miss_d = miss_q + 4'd1;
                            end
                        end else begin
                            last_d  = rect_time;
                            state_d = ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    ring_d[ptr_q] = last_q;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (cnt_q == CNT_W'(DEPTH)) begin
                        sum_d = sum_q - SUM_W'(evicted) + SUM_W'(last_q);
                    end else begin
                        sum_d = sum_q + SUM_W'(last_q);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last_q < best_q) begin
                        best_d = last_q;
                    end
`ifdef STATS_WORST_EN
                    if (last_q > worst_q) begin
                        worst_d = last_q;
                    end
`endif
                    valid_d   = 1'b0;
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        avg_d   = div_quot;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LAST;
            last_q  <= '0;
            best_q  <= '1;
`ifdef STATS_WORST_EN
            worst_q <= '0;
`endif
            avg_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            disp_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            best_q  <= best_d;
`ifdef STATS_WORST_EN
            worst_q <= worst_d;
`endif
            avg_q   <= avg_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= ring_d[i];
            end
        end
    end

    // Divider takes the post-update sum and count in the same cycle they are
    // written, so it starts without waiting for the registers to settle.
    stats_div #(
        .WIDTH (WIDTH),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .start    (div_start),
        .dividend (sum_d),
        .divisor  (cnt_d),
        .quotient (div_quot),
        .done     (div_done)
    );

    assign ready       = (state_q == ST_IDLE);
    assign disp_time   = disp_q;
    assign disp_mode   = mode_q;
    assign trial_cnt   = cnt_q;
    assign miss_cnt    = miss_q;
    assign stats_valid = valid_q;

endmodule

// File: tb/tb_reaction_stats.sv
// tb/tb_reaction_stats.sv - randomized and directed self-checking bench for reaction_stats
module tb_reaction_stats;

    localparam int WIDTH = 14;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int SUM_W = WIDTH + 3;
`ifdef STATS_WORST_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trial_valid = 1'b0;
    logic [WIDTH-1:0] rect_time = '0;
    logic             overflow = 1'b0;
    logic             mode_btn = 1'b0;
    logic             clear = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] disp_time;
    logic [1:0]       disp_mode;
    logic [CNT_W-1:0] trial_cnt;
    logic [3:0]       miss_cnt;
    logic             stats_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    reaction_stats #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trial_valid (trial_valid),
        .rect_time   (rect_time),
        .overflow    (overflow),
        .mode_btn    (mode_btn),
        .clear       (clear),
        .ready       (ready),
        .disp_time   (disp_time),
        .disp_mode   (disp_mode),
        .trial_cnt   (trial_cnt),
        .miss_cnt    (miss_cnt),
        .stats_valid (stats_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the window is a queue; age counts cycles since a
    // trial was accepted (-1 when idle). Stats appear one cycle after
    // acceptance, the average SUM_W+2 cycles after acceptance.
    int m_win[$];
    int m_last = 0, m_best = 16383, m_worst = 0, m_avg = 0, m_cnt = 0;
    int m_miss = 0, m_mode = 0, m_sv = 0, m_disp = 0, m_age = -1;
    int m_nd, m_sum;

    function automatic int model_disp();
        if (m_cnt == 0) return 0;
        case (m_mode)
            0: return m_last;
            1: return m_best;
            2: return m_avg;
            default: return m_worst;
        endcase
    endfunction

    task automatic model_clear();
        m_win.delete();
        m_last = 0; m_best = 16383; m_worst = 0; m_avg = 0; m_cnt = 0;
        m_miss = 0; m_sv = 0; m_disp = 0; m_age = -1;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
            m_mode = 0;
        end else begin
            m_nd = model_disp();
            if (mode_btn) m_mode = (m_mode + 1) % NMODES;
            if (clear) begin
                model_clear();
            end else begin
                m_disp = m_nd;
                if (m_age >= 0) begin
                    m_age++;
                    if (m_age == 1) begin
                        m_win.push_back(m_last);
                        if (m_win.size() > DEPTH) void'(m_win.pop_front());
                        m_cnt = m_win.size();
                        if (m_last < m_best) m_best = m_last;
                        if (m_last > m_worst) m_worst = m_last;
                        m_sv = 0;
                    end else if (m_age == SUM_W + 2) begin
                        m_sum = 0;
                        foreach (m_win[i]) m_sum += m_win[i];
                        m_avg = m_sum / m_win.size();
                        m_sv = 1;
                        m_age = -1;
                    end
                end else if (trial_valid) begin
                    if (overflow) begin
                        if (m_miss < 15) m_miss++;
                    end else begin
                        m_last = int'(rect_time);
                        m_age = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",       int'(ready),       (m_age < 0) ? 1 : 0);
            check("trial_cnt",   int'(trial_cnt),   m_cnt);
            check("miss_cnt",    int'(miss_cnt),    m_miss);
            check("disp_mode",   int'(disp_mode),   m_mode);
            check("stats_valid", int'(stats_valid), m_sv);
            check("disp_time",   int'(disp_time),   m_disp);
        end
    end

    task automatic step(input bit tv, input int rt, input bit ov, input bit mb, input bit cl);
        trial_valid = tv;
        rect_time   = rt[WIDTH-1:0];
        overflow    = ov;
        mode_btn    = mb;
        clear       = cl;
        @(negedge clk);
        trial_valid = 1'b0;
        overflow    = 1'b0;
        mode_btn    = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) step(0, 0, 0, 0, 0);
        check("wait_ready", int'(ready), 1);
    endtask

    task automatic trial(input int rt);
        wait_ready();
        step(1, rt, 0, 0, 0);
    endtask

    task automatic set_mode(input int m);
        for (int i = 0; i < 4 && int'(disp_mode) != m; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("set_mode", int'(disp_mode), m);
    endtask

    initial begin
        int edges;
        int m0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", int'(ready), 1);
        check("rst_disp_time", int'(disp_time), 0);
        check("rst_trial_cnt", int'(trial_cnt), 0);
        check("rst_stats_valid", int'(stats_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 200, 300, 100: latency of the third trial and the resulting stats
        trial(200);
        trial(300);
        wait_ready();
        step(1, 100, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        edges = 2;
        while (!stats_valid && edges < 200) begin
            step(0, 0, 0, 0, 0);
            edges++;
        end
        check("latency", edges, SUM_W + 3);
        check("cnt3", int'(trial_cnt), 3);
        set_mode(0); check("last100", int'(disp_time), 100);
        set_mode(1); check("best100", int'(disp_time), 100);
        set_mode(2); check("avg200", int'(disp_time), 200);
`ifdef STATS_WORST_EN
        set_mode(3); check("worst300", int'(disp_time), 300);
`endif

        // ten trials 10..100: window average and all-time best
        step(0, 0, 0, 0, 1);
        for (int v = 10; v <= 100; v += 10) trial(v);
        wait_ready();
        check("cnt8", int'(trial_cnt), 8);
        set_mode(2); check("avg65", int'(disp_time), 65);
        set_mode(1); check("best10", int'(disp_time), 10);
        set_mode(0); check("last_100", int'(disp_time), 100);

        // overflow trials: counted, not stored, saturating
        step(1, 9999, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("miss1", int'(miss_cnt), 1);
        check("ovf_cnt", int'(trial_cnt), 8);
        check("ovf_disp", int'(disp_time), 100);
        repeat (16) step(1, 9999, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("miss15", int'(miss_cnt), 15);

        // trial_valid while busy is dropped
        step(0, 0, 0, 0, 1);
        trial(50);
        step(0, 0, 0, 0, 0);
        step(1, 60, 0, 0, 0);
        wait_ready();
        check("drop_cnt", int'(trial_cnt), 1);
        check("drop_last", int'(disp_time), 50);

        // clear together with trial_valid in the middle of a divide
        trial(70);
        repeat (5) step(0, 0, 0, 0, 0);
        m0 = int'(disp_mode);
        step(1, 80, 0, 0, 1);
        check("clr_cnt", int'(trial_cnt), 0);
        check("clr_sv", int'(stats_valid), 0);
        check("clr_disp", int'(disp_time), 0);
        check("clr_ready", int'(ready), 1);
        check("clr_mode", int'(disp_mode), m0);

        // mode cycling
        set_mode(0);
        for (int i = 1; i <= NMODES; i++) begin
            step(0, 0, 0, 1, 0);
            check("mode_seq", int'(disp_mode), i % NMODES);
        end

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int rt;
            rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 500));
            step($urandom_range(0, 3) == 0, rt, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
        end
        wait_ready();
        step(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
